// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I fetch constants
// Common address width, instruction size and reset vector for fetch/branch units.
package core_pkg;
  localparam int          XLEN                 = 32;
  localparam int          INSTR_BYTES          = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_align_chk.sv
// rtl/pc_align_chk.sv - instruction-address alignment checker
// Flags an address that violates IALIGN (32: low two bits, 16: bit 0).
module pc_align_chk #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int IALIGN = 32
) (
  input  logic [XLEN-1:0] addr,
  output logic            misaligned
);

  // Upper address bits never affect alignment; fold them away explicitly.
  logic unused_bits;
  assign unused_bits = ^addr;

  generate
    if (IALIGN == 16) begin : g_ialign16
      assign misaligned = addr[0];
    end else begin : g_ialign32
      assign misaligned = |addr[1:0];
    end
  endgenerate

endmodule

// File: rtl/pc.sv
// rtl/pc.sv - RV32I program counter at the head of the fetch stage
// Optional macro PC_STALL_EN adds a pc_stall input that holds the PC.
module pc #(
  parameter int              XLEN         = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(core_pkg::RESET_VECTOR_DEFAULT),
  parameter int              IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_next,
`ifdef PC_STALL_EN
  input  logic            pc_stall,
`endif
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_misaligned
);

  logic misaligned_next;

  pc_align_chk #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_align_chk (
    .addr       (pc_next),
    .misaligned (misaligned_next)
  );

  // Reset has priority over stall, so a stalled core still resets at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_current    <= RESET_VECTOR;
      pc_misaligned <= 1'b0;
    end else begin
`ifdef PC_STALL_EN
      if (!pc_stall) begin
        pc_current    <= pc_next;
        pc_misaligned <= misaligned_next;
      end
`else
      pc_current    <= pc_next;
      pc_misaligned <= misaligned_next;
`endif
    end
  end

  assign pc_plus4 = pc_current + XLEN'(core_pkg::INSTR_BYTES);

endmodule

// File: tb/tb_pc.sv
// tb/tb_pc.sv - directed self-checking bench for pc
// Covers reset, sequencing, wrap, alignment (IALIGN 32 and 16), async reset, stall.
module tb_pc;
  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
`ifdef PC_STALL_EN
  logic        pc_stall;
`endif
  logic [31:0] pc_current, pc_plus4;
  logic        pc_misaligned;
  logic [31:0] pc_current16, pc_plus4_16;
  logic        pc_misaligned16;

  int checks = 0;
  int errors = 0;

  pc u_dut (
    .clk           (clk),
    .rst           (rst),
    .pc_next       (pc_next),
`ifdef PC_STALL_EN
    .pc_stall      (pc_stall),
`endif
    .pc_current    (pc_current),
    .pc_plus4      (pc_plus4),
    .pc_misaligned (pc_misaligned)
  );

  pc #(.IALIGN(16)) u_dut16 (
    .clk           (clk),
    .rst           (rst),
    .pc_next       (pc_next),
`ifdef PC_STALL_EN
    .pc_stall      (pc_stall),
`endif
    .pc_current    (pc_current16),
    .pc_plus4      (pc_plus4_16),
    .pc_misaligned (pc_misaligned16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    pc_next = 32'h40;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pc_current !== 32'h0) begin
        errors++;
        $display("FAIL reset_pc cyc%0d: got %h expected %h", i, pc_current, 32'h0);
      end
      checks++;
      if (pc_misaligned !== 1'b0) begin
        errors++;
        $display("FAIL reset_mis cyc%0d: got %b expected 0", i, pc_misaligned);
      end
    end
  endtask

  task automatic test_sequence();
    logic [31:0] vals [3];
    vals = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst     = 1'b1;
      pc_next = vals[i];
      tick();
      checks++;
      if (pc_current !== vals[i]) begin
        errors++;
        $display("FAIL seq_pc %0d: got %h expected %h", i, pc_current, vals[i]);
      end
      checks++;
      if (pc_plus4 !== vals[i] + 32'd4) begin
        errors++;
        $display("FAIL seq_plus4 %0d: got %h expected %h", i, pc_plus4, vals[i] + 32'd4);
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    pc_next = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (pc_current !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pc: got %h expected %h", pc_current, 32'hFFFF_FFFC);
    end
    checks++;
    if (pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_plus4: got %h expected %h", pc_plus4, 32'h0);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [5];
    logic        exp32 [5];
    logic        exp16 [5];
    addrs = '{32'h6, 32'h8, 32'h2, 32'h5, 32'h1003};
    exp32 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp16 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pc_next = addrs[i];
      tick();
      checks++;
      if (pc_current !== addrs[i]) begin
        errors++;
        $display("FAIL mis_pc %0d: got %h expected %h", i, pc_current, addrs[i]);
      end
      checks++;
      if (pc_misaligned !== exp32[i]) begin
        errors++;
        $display("FAIL mis32 %0d: got %b expected %b", i, pc_misaligned, exp32[i]);
      end
      checks++;
      if (pc_misaligned16 !== exp16[i]) begin
        errors++;
        $display("FAIL mis16 %0d: got %b expected %b", i, pc_misaligned16, exp16[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pc_next = 32'h8;
    tick();
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (pc_current !== 32'h0) begin
      errors++;
      $display("FAIL async_pc: got %h expected %h", pc_current, 32'h0);
    end
    // Misaligned flag must also clear asynchronously.
    @(negedge clk);
    rst     = 1'b1;
    pc_next = 32'h6;
    tick();
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (pc_current !== 32'h0 || pc_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL async_mis: got %h/%b expected 00000000/0", pc_current, pc_misaligned);
    end
    // X on pc_next during reset must not leak through.
    pc_next = 'x;
    tick();
    checks++;
    if (pc_current !== 32'h0 || pc_misaligned !== 1'b0 || pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_x: got %h/%b/%h expected 00000000/0/00000004",
               pc_current, pc_misaligned, pc_plus4);
    end
    @(negedge clk);
    rst     = 1'b1;
    pc_next = 32'h100;
    #1;
    checks++;
    if (pc_current !== 32'h0) begin
      errors++;
      $display("FAIL release_pre_edge: got %h expected %h", pc_current, 32'h0);
    end
    tick();
    checks++;
    if (pc_current !== 32'h100) begin
      errors++;
      $display("FAIL release_first_edge: got %h expected %h", pc_current, 32'h100);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals = '{32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEC, 32'h0000_0010};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc_next = vals[i];
      tick();
      checks++;
      if (pc_current !== vals[i] || pc_plus4 !== vals[i] + 32'd4) begin
        errors++;
        $display("FAIL b2b %0d: got %h/%h expected %h/%h",
                 i, pc_current, pc_plus4, vals[i], vals[i] + 32'd4);
      end
    end
  endtask

`ifdef PC_STALL_EN
  task automatic test_stall();
    @(negedge clk);
    pc_next = 32'h4;
    tick();
    @(negedge clk);
    pc_stall = 1'b1;
    pc_next  = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_current !== 32'h4) begin
        errors++;
        $display("FAIL stall_hold %0d: got %h expected %h", i, pc_current, 32'h4);
      end
    end
    @(negedge clk);
    pc_stall = 1'b0;
    tick();
    checks++;
    if (pc_current !== 32'h8) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", pc_current, 32'h8);
    end
    @(negedge clk);
    pc_stall = 1'b1;
    rst      = 1'b0;
    #1;
    checks++;
    if (pc_current !== 32'h0) begin
      errors++;
      $display("FAIL stall_reset: got %h expected %h", pc_current, 32'h0);
    end
    @(negedge clk);
    rst      = 1'b1;
    pc_stall = 1'b0;
  endtask
`endif

  initial begin
`ifdef PC_STALL_EN
    pc_stall = 1'b0;
`endif
    test_reset();
    test_sequence();
    test_wrap();
    test_misaligned();
    test_async_reset();
    test_back_to_back();
`ifdef PC_STALL_EN
    test_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
